// File: rtl/display_ctrl_pkg.sv
// rtl/display_ctrl_pkg.sv - shared state encoding and display character set
package display_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SECOND,
    ST_LATCH,
    ST_SEND,
    ST_WAIT_TX
  } ctrl_state_t;

  // The decoder imports these too, so both blocks agree on what is displayable
  localparam logic [7:0] CHAR_ONE = 8'h31;
  localparam logic [7:0] CHAR_P   = 8'h50;

  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'h06;
  localparam logic [7:0] DEFAULT_NAK_BYTE = 8'h15;

  function automatic logic is_display_char(input logic [7:0] b);
    return (b == CHAR_ONE) || (b == CHAR_P);
  endfunction

endpackage

// File: rtl/inter_byte_timer.sv
// rtl/inter_byte_timer.sv - saturating inter-byte timer, expires at TIMEOUT_CYCLES-1
module inter_byte_timer #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Holds at LAST so a late enable can never wrap the count back to zero
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/display_frame_controller.sv
// rtl/display_frame_controller.sv - two-byte frame assembly, decoder hold registers, ACK/NAK handshake
module display_frame_controller
  import display_ctrl_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 50_000_000,
  parameter logic [7:0] ACK_BYTE       = DEFAULT_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE       = DEFAULT_NAK_BYTE
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] primeroByte,
  output logic [7:0] segundoByte,
  output logic       frame_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       timeout_err,
  output logic       overrun,
  output logic       busy
);

  ctrl_state_t state, state_next;

  logic [7:0] first_byte, first_next;
  logic [7:0] second_byte, second_next;
  logic [7:0] primero_next, segundo_next, tx_data_next;
  logic       frame_valid_next, tx_start_next, timeout_next;
  logic       timer_clear, timer_enable, timer_expired;

  inter_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      first_byte  <= '0;
      second_byte <= '0;
      primeroByte <= '0;
      segundoByte <= '0;
      frame_valid <= 1'b0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      first_byte  <= first_next;
      second_byte <= second_next;
      primeroByte <= primero_next;
      segundoByte <= segundo_next;
      frame_valid <= frame_valid_next;
      tx_data     <= tx_data_next;
      tx_start    <= tx_start_next;
      timeout_err <= timeout_next;
    end
  end

  always_comb begin
    state_next       = state;
    first_next       = first_byte;
    second_next      = second_byte;
    primero_next     = primeroByte;
    segundo_next     = segundoByte;
    frame_valid_next = 1'b0;
    tx_data_next     = tx_data;
    tx_start_next    = tx_start;
    timeout_next     = 1'b0;
    timer_clear      = 1'b0;
    timer_enable     = 1'b0;

    case (state)
      ST_IDLE: begin
        timer_clear = 1'b1;
        if (rx_valid) begin
          first_next = rx_data;
          state_next = ST_WAIT_SECOND;
        end
      end
      ST_WAIT_SECOND: begin
        timer_enable = 1'b1;
        // A byte arriving in the expiry cycle wins over the timeout
        if (rx_valid) begin
          second_next = rx_data;
          state_next  = ST_LATCH;
        end else if (timer_expired) begin
          timeout_next = 1'b1;
          first_next   = '0;
          state_next   = ST_IDLE;
        end
      end
      ST_LATCH: begin
        primero_next     = first_byte;
        segundo_next     = second_byte;
        frame_valid_next = 1'b1;
        tx_data_next     = is_display_char(second_byte) ? ACK_BYTE : NAK_BYTE;
        state_next       = ST_SEND;
      end
      ST_SEND: begin
        if (tx_busy) begin
          tx_start_next = 1'b0;
          state_next    = ST_WAIT_TX;
        end else begin
          tx_start_next = 1'b1;
        end
      end
      ST_WAIT_TX: begin
        if (!tx_busy) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy    = (state == ST_LATCH) || (state == ST_SEND) || (state == ST_WAIT_TX);
  assign overrun = rx_valid && busy;

endmodule

// File: tb/tb_display_frame_controller.sv
// tb/tb_display_frame_controller.sv - randomized and directed bench with behavioural frame model
module tb_display_frame_controller;

  localparam int T = 100;

  logic       clock;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] primeroByte;
  logic [7:0] segundoByte;
  logic       frame_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       timeout_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  display_frame_controller #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .primeroByte (primeroByte),
    .segundoByte (segundoByte),
    .frame_valid (frame_valid),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .timeout_err (timeout_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frame progress tracked by edge stamps and handshake flags
  int         edge_no;
  int         m_first_at;
  logic [7:0] m_first, m_second;
  logic       m_latch_pending, m_in_send, m_in_tx;
  logic [7:0] m_primero, m_segundo, m_tx_data;
  logic       m_fv, m_tx_start, m_to;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      edge_no = 0; m_first_at = -1;
      m_first = 0; m_second = 0;
      m_latch_pending = 0; m_in_send = 0; m_in_tx = 0;
      m_primero = 0; m_segundo = 0; m_tx_data = 0;
      m_fv = 0; m_tx_start = 0; m_to = 0;
    end else begin
      edge_no++;
      m_fv = 0;
      m_to = 0;
      if (m_latch_pending) begin
        m_primero = m_first;
        m_segundo = m_second;
        m_fv = 1;
        m_tx_data = (m_second == 8'h31 || m_second == 8'h50) ? 8'h06 : 8'h15;
        m_latch_pending = 0;
        m_in_send = 1;
      end else if (m_in_send) begin
        if (tx_busy) begin
          m_tx_start = 0;
          m_in_send = 0;
          m_in_tx = 1;
        end else begin
          m_tx_start = 1;
        end
      end else if (m_in_tx) begin
        if (!tx_busy) m_in_tx = 0;
      end else if (m_first_at >= 0) begin
        if (rx_valid) begin
          m_second = rx_data;
          m_latch_pending = 1;
          m_first_at = -1;
        end else if (edge_no - m_first_at == T) begin
          m_to = 1;
          m_first_at = -1;
        end
      end else if (rx_valid) begin
        m_first = rx_data;
        m_first_at = edge_no;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      check("primeroByte", primeroByte, m_primero);
      check("segundoByte", segundoByte, m_segundo);
      check("frame_valid", frame_valid, m_fv);
      check("tx_data", tx_data, m_tx_data);
      check("tx_start", tx_start, m_tx_start);
      check("timeout_err", timeout_err, m_to);
      check("busy", busy, m_latch_pending || m_in_send || m_in_tx);
      check("overrun", overrun, rx_valid && (m_latch_pending || m_in_send || m_in_tx));
    end
  end

  // Transmitter emulation: raises tx_busy some cycles after tx_start
  logic tx_auto;
  int   tx_delay, tx_len, tx_phase, tx_cnt;

  always begin
    @(posedge clock); #1;
    if (!tx_auto) begin
      tx_phase = 0;
    end else if (!reset_n) begin
      tx_phase = 0;
      tx_busy = 0;
    end else begin
      case (tx_phase)
        0: if (tx_start) begin tx_cnt = tx_delay; tx_phase = 1; end
        1: if (tx_cnt <= 1) begin tx_busy = 1; tx_cnt = tx_len; tx_phase = 2; end
           else tx_cnt--;
        default: if (tx_cnt <= 1) begin tx_busy = 0; tx_phase = 0; end
                 else tx_cnt--;
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || m_first_at >= 0) && n < 400) begin
      step(1);
      n++;
    end
    check("idle_reached", (n < 400), 1);
  endtask

  initial begin
    int got, permille;
    logic [7:0] b;
    reset_n = 1'b1; rx_data = 0; rx_valid = 0; tx_busy = 0;
    tx_auto = 1; tx_delay = 2; tx_len = 2;
    #2 reset_n = 1'b0;
    #1;
    check("rst_primero", primeroByte, 8'h00);
    check("rst_segundo", segundoByte, 8'h00);
    check("rst_tx_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_data", tx_data, 8'h00);
    step(2);
    reset_n = 1'b1;
    step(1);

    // ACK frame, bytes three cycles apart
    send_byte(8'h41); step(2); send_byte(8'h31);
    step(1);
    check("ack_fv", frame_valid, 1);
    check("ack_primero", primeroByte, 8'h41);
    check("ack_segundo", segundoByte, 8'h31);
    step(1);
    check("ack_fv_drop", frame_valid, 0);
    check("ack_tx_data", tx_data, 8'h06);
    check("ack_tx_start", tx_start, 1);
    wait_idle();

    // NAK frame still updates the display
    send_byte(8'h00); send_byte(8'h7A);
    wait_idle();
    check("nak_primero", primeroByte, 8'h00);
    check("nak_segundo", segundoByte, 8'h7A);
    check("nak_tx_data", tx_data, 8'h15);

    // Lone byte times out exactly T clocks after capture
    send_byte(8'h50);
    got = -1;
    for (int i = 1; i <= T + 50; i++) begin
      step(1);
      if (timeout_err) begin got = i; break; end
    end
    check("timeout_latency", got, T);
    check("timeout_idle", busy, 0);
    check("timeout_display", segundoByte, 8'h7A);
    send_byte(8'h12); send_byte(8'h50);
    wait_idle();
    check("fresh_primero", primeroByte, 8'h12);
    check("fresh_tx_data", tx_data, 8'h06);

    // Second byte on the last accepted edges; one edge later is a timeout
    send_byte(8'h61); step(T - 2); send_byte(8'h31);
    wait_idle();
    check("late99_primero", primeroByte, 8'h61);
    send_byte(8'h62); step(T - 1); send_byte(8'h50);
    wait_idle();
    check("late100_primero", primeroByte, 8'h62);
    send_byte(8'h63); step(T); send_byte(8'h64);
    check("late101_waiting", (m_first_at >= 0), 1);
    step(T + 5);
    check("late101_display", primeroByte, 8'h62);

    // tx_busy already high when SEND is entered
    tx_auto = 0; tx_busy = 1;
    send_byte(8'h31); send_byte(8'h50);
    step(2);
    check("prebusy_tx_start", tx_start, 0);
    step(2);
    tx_busy = 0;
    tx_auto = 1;
    wait_idle();

    // Overrun while the transmitter is busy for 10 cycles
    tx_delay = 1; tx_len = 10;
    send_byte(8'h21); send_byte(8'h50);
    got = 0;
    while (!tx_busy && got < 30) begin step(1); got++; end
    check("overrun_busy_seen", (got < 30), 1);
    step(1);
    rx_data = 8'h33; rx_valid = 1'b1;
    #2;
    check("overrun_pulse", overrun, 1);
    @(posedge clock); #1;
    rx_valid = 1'b0;
    wait_idle();
    check("overrun_primero", primeroByte, 8'h21);
    check("overrun_segundo", segundoByte, 8'h50);

    // Asynchronous reset during SEND
    tx_auto = 0; tx_busy = 0;
    send_byte(8'h44); send_byte(8'h31);
    step(3);
    check("send_reached", tx_start, 1);
    #3 reset_n = 1'b0;
    #1;
    check("arst_tx_start", tx_start, 0);
    check("arst_busy", busy, 0);
    check("arst_primero", primeroByte, 8'h00);
    check("arst_segundo", segundoByte, 8'h00);
    @(posedge clock); #1;
    reset_n = 1'b1;
    tx_auto = 1; tx_delay = 2; tx_len = 2;
    send_byte(8'h50); send_byte(8'h31);
    wait_idle();
    check("post_rst_primero", primeroByte, 8'h50);
    check("post_rst_tx_data", tx_data, 8'h06);

    // Randomized traffic across several byte densities
    for (int seg = 0; seg < 20; seg++) begin
      case ($urandom_range(0, 3))
        0: permille = 5;
        1: permille = 20;
        2: permille = 100;
        default: permille = 400;
      endcase
      tx_delay = $urandom_range(0, 4);
      tx_len = $urandom_range(1, 6);
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 999) < permille) begin
          if ($urandom_range(0, 2) == 0) b = ($urandom_range(0, 1) != 0) ? 8'h31 : 8'h50;
          else b = 8'($urandom_range(0, 255));
          rx_data = b;
          rx_valid = 1'b1;
        end else begin
          rx_valid = 1'b0;
        end
        step(1);
      end
    end
    rx_valid = 1'b0;
    wait_idle();
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
